// File: rtl/adc_serial_reader.sv
// Serial ADC read master: drives CS_N/SCLK from clk_X4 (SCLK = clk_X4/4), skips the lead bits and
// shifts in an MSB-first sample, presenting it as a parallel word with a one-cycle valid strobe.
module adc_serial_reader #(
    parameter int DATA_W     = 12,
    parameter int LEAD_BITS  = 3,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk_X4,
    input  logic              rst,
    input  logic              enable,
    input  logic              start,
    input  logic              continuous,
    input  logic              DOUT,
    output logic              SCLK,
    output logic              CS_N,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int MAXC = (DATA_W > GAP_CYCLES) ? ((DATA_W > LEAD_BITS) ? DATA_W : LEAD_BITS)
                                                : ((GAP_CYCLES > LEAD_BITS) ? GAP_CYCLES : LEAD_BITS);
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, LEAD, SHIFT, DONE, GAP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start || continuous) begin
                    state_d = SETUP;
                    phase_d = '0;
                    cnt_d   = '0;
                end
                SETUP: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) state_d = LEAD;
                end
                LEAD: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (cnt_q == CW'(LEAD_BITS - 1)) begin
                            state_d = SHIFT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = GAP;
                    phase_d = '0;
                    cnt_d   = '0;
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = continuous ? SETUP : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so pins change cleanly on the same edge as state.
    always_ff @(negedge clk_X4) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            SCLK       <= 1'b1;
            CS_N       <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            CS_N       <= !(state_d == SETUP || state_d == LEAD || state_d == SHIFT);
            SCLK       <= (state_d == LEAD || state_d == SHIFT) ? phase_d[1] : 1'b1;
            data_valid <= (state_d == DONE);
            // Sample on the edge that ends phase 1, where SCLK rises.
            if (state_q == SHIFT && phase_q == 2'd1 && enable)
                shift_q <= {shift_q[DATA_W-2:0], DOUT};
            if (state_d == DONE)
                data_out <= shift_q;
            if (start && busy)
                overrun <= 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: ADC pin model fed from a word queue, scoreboard of expected samples.
module tb_adc_serial_reader;

    localparam int DATA_W = 12;
    localparam int LEAD   = 3;
    localparam int GAP    = 16;
    localparam int LAT    = 4 + 4 * LEAD + 4 * DATA_W;
    localparam int PERIOD = LAT + 1 + GAP;

    logic              clk_X4 = 1'b1;
    logic              rst, enable, start, continuous, DOUT;
    logic              SCLK, CS_N, data_valid, busy, overrun;
    logic [DATA_W-1:0] data_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;

    logic [DATA_W-1:0] adc_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_word = '0;
    int                fall_cnt = 0;

    adc_serial_reader #(.DATA_W(DATA_W), .LEAD_BITS(LEAD), .GAP_CYCLES(GAP)) dut (
        .clk_X4(clk_X4), .rst(rst), .enable(enable), .start(start), .continuous(continuous),
        .DOUT(DOUT), .SCLK(SCLK), .CS_N(CS_N), .data_out(data_out), .data_valid(data_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk_X4 = ~clk_X4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: new word per CS_N fall, next bit driven on each SCLK fall, lead bits driven as 1.
    always @(negedge CS_N) begin
        fall_cnt = 0;
        cur_word = (adc_q.size() != 0) ? adc_q.pop_front() : '0;
        DOUT     = 1'b1;
    end

    always @(negedge SCLK) begin
        if (!CS_N) begin
            int idx;
            fall_cnt++;
            idx  = fall_cnt - 1 - LEAD;
            DOUT = (idx >= 0 && idx < DATA_W) ? cur_word[DATA_W-1-idx] : 1'b1;
        end
    end

    // Scoreboard and pin-protocol monitor, sampled on the edge opposite to the DUT.
    logic prev_valid = 1'b0;
    logic prev_cs    = 1'b1;
    always @(posedge clk_X4) begin
        if (data_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            if (prev_valid) check("valid_back_to_back", 32'd1, 32'd0);
        end
        if (CS_N !== prev_cs) check("sclk_on_cs_edge", 32'(SCLK), 32'd1);
        prev_valid = data_valid;
        prev_cs    = CS_N;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_X4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_X4);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int cs_hi);
        cyc = 0;
        cs_hi = 0;
        while (cyc < 300) begin
            @(posedge clk_X4);
            cyc++;
            if (data_valid) return;
            if (CS_N) cs_hi++;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc, hi, nv;
        logic [DATA_W-1:0] words [3];
        words[0] = 12'hFFF; words[1] = 12'h000; words[2] = 12'h801;
        rst = 1'b1; enable = 1'b1; start = 1'b0; continuous = 1'b0;
        tick(3);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_cs_n", 32'(CS_N), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(2);

        // Extremes: MSB-first ordering and all-ones/all-zeros words.
        for (int i = 0; i < 3; i++) begin
            adc_q.push_back(words[i]);
            exp_q.push_back(words[i]);
            pulse_start();
            wait_valid(cyc, hi);
            check("ext_latency", 32'(cyc), 32'(LAT));
            tick(GAP + 2);
        end

        // Single read with detailed timing.
        adc_q.push_back(12'hA5C);
        exp_q.push_back(12'hA5C);
        start = 1'b1;
        @(posedge clk_X4);
        start = 1'b0;
        check("single_cs_low", 32'(CS_N), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        wait_valid(cyc, hi);
        check("single_latency", 32'(cyc + 1), 32'(LAT + 1));
        check("done_cs_n", 32'(CS_N), 32'd1);
        check("done_sclk", 32'(SCLK), 32'd1);
        check("sclk_falls", 32'(fall_cnt), 32'(LEAD + DATA_W));
        tick(GAP);
        check("gap_last_busy", 32'(busy), 32'd1);
        tick(1);
        check("idle_busy", 32'(busy), 32'd0);
        tick(2);

        // Abort during SHIFT bit 5.
        adc_q.push_back(12'h5A5);
        nv = n_valid;
        pulse_start();
        tick(37);
        check("abort_sclk_low", 32'(SCLK), 32'd0);
        enable = 1'b0;
        tick(1);
        check("abort_cs_n", 32'(CS_N), 32'd1);
        check("abort_sclk", 32'(SCLK), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick(80);
        check("abort_no_valid", 32'(n_valid - nv), 32'd0);
        check("abort_data_kept", 32'(data_out), 32'hA5C);
        adc_q.push_back(12'h6B9);
        exp_q.push_back(12'h6B9);
        pulse_start();
        wait_valid(cyc, hi);
        check("after_abort_latency", 32'(cyc), 32'(LAT));
        tick(GAP + 2);

        // Continuous: three back-to-back frames.
        for (int i = 0; i < 3; i++) begin
            adc_q.push_back(12'(12'h100 + i));
            exp_q.push_back(12'(12'h100 + i));
        end
        continuous = 1'b1;
        wait_valid(cyc, hi);
        check("cont_first_latency", 32'(cyc), 32'(LAT + 1));
        for (int i = 1; i < 3; i++) begin
            wait_valid(cyc, hi);
            if (i == 2) continuous = 1'b0;
            check("cont_period", 32'(cyc), 32'(PERIOD));
            check("cont_cs_high", 32'(hi + 1), 32'(GAP + 1));
        end
        tick(GAP + 4);
        check("cont_stop_idle", 32'(busy), 32'd0);

        // Overrun: second start 20 cycles into a conversion.
        adc_q.push_back(12'h3C3);
        exp_q.push_back(12'h3C3);
        nv = n_valid;
        pulse_start();
        tick(19);
        check("pre_overrun", 32'(overrun), 32'd0);
        pulse_start();
        check("overrun_set", 32'(overrun), 32'd1);
        wait_valid(cyc, hi);
        check("overrun_latency", 32'(cyc + 21), 32'(LAT + 1));
        tick(120);
        check("overrun_single_valid", 32'(n_valid - nv), 32'd1);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("overrun_idle", 32'(busy), 32'd0);

        // Reset during LEAD.
        adc_q.push_back(12'h777);
        pulse_start();
        tick(7);
        check("lead_cs_low", 32'(CS_N), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_sclk", 32'(SCLK), 32'd1);
        check("mrst_cs_n", 32'(CS_N), 32'd1);
        check("mrst_data_out", 32'(data_out), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        tick(2);
        adc_q.push_back(12'h2D4);
        exp_q.push_back(12'h2D4);
        pulse_start();
        wait_valid(cyc, hi);
        check("mrst_next_latency", 32'(cyc), 32'(LAT));
        tick(GAP + 4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
